// File: rtl/bias2_update_sched_if.sv
// Bundle between the training sequencer/backprop side and the bias2 update scheduler.
// Master drives the batch controls and per-sample gradients; slave returns the bias bank drive and status.
interface bias2_update_sched_if;
  logic               start;
  logic               abort;
  logic               delta_valid;
  logic signed [15:0] g1;
  logic signed [15:0] g2;
  logic signed [15:0] g3;
  logic signed [15:0] g4;
  logic signed [15:0] g5;
  logic [3:0]         ctrl;
  logic [3:0]         step;
  logic signed [15:0] deltab2_1;
  logic signed [15:0] deltab2_2;
  logic signed [15:0] deltab2_3;
  logic signed [15:0] deltab2_4;
  logic signed [15:0] deltab2_5;
  logic               busy;
  logic               done;
  logic [15:0]        update_count;

  modport master (
    output start, abort, delta_valid, g1, g2, g3, g4, g5,
    input  ctrl, step, deltab2_1, deltab2_2, deltab2_3, deltab2_4, deltab2_5,
    input  busy, done, update_count
  );

  modport slave (
    input  start, abort, delta_valid, g1, g2, g3, g4, g5,
    output ctrl, step, deltab2_1, deltab2_2, deltab2_3, deltab2_4, deltab2_5,
    output busy, done, update_count
  );
endinterface

// File: rtl/bias2_update_sched.sv
// Averages a mini-batch of five-lane bias gradients and issues one bias-bank apply cycle per batch.
// Apply is visible the cycle after the last sample edge, done one cycle later; delta_valid=0 simply stalls.
module bias2_update_sched #(
  parameter int BATCH_LOG2 = 2,
  parameter int LR_SHIFT   = 0,
  parameter int ACC_W      = 24
) (
  input logic clk,
  input logic rst,
  bias2_update_sched_if.slave bus
);

  localparam int SH = BATCH_LOG2 + LR_SHIFT;
  localparam int NL = 5;

  typedef enum logic [1:0] {IDLE, ACCUM, APPLY, DONE} state_t;

  state_t                  state;
  logic signed [ACC_W-1:0] acc     [NL];
  logic signed [ACC_W-1:0] acc_nxt [NL];
  logic signed [15:0]      g       [NL];
  logic signed [15:0]      dlt     [NL];
  logic signed [15:0]      dlt_nxt [NL];
  logic [BATCH_LOG2-1:0]   sample_cnt;
  logic [3:0]              step_cnt;
  logic [3:0]              ctrl_r;
  logic [3:0]              step_r;
  logic                    busy_r;
  logic                    done_r;
  logic [15:0]             upd_cnt;

  assign g[0] = bus.g1;
  assign g[1] = bus.g2;
  assign g[2] = bus.g3;
  assign g[3] = bus.g4;
  assign g[4] = bus.g5;

  // Deltas come from the sum including the sample being accepted, so they are ready on the apply edge.
  always_comb begin
    for (int i = 0; i < NL; i++) begin
      acc_nxt[i] = acc[i] + {{(ACC_W-16){g[i][15]}}, g[i]};
      dlt_nxt[i] = 16'(acc_nxt[i] >>> SH);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ctrl_r     <= 4'd0;
      step_r     <= 4'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      upd_cnt    <= 16'd0;
      step_cnt   <= 4'd1;
      sample_cnt <= '0;
      for (int i = 0; i < NL; i++) begin
        acc[i] <= '0;
        dlt[i] <= '0;
      end
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state      <= ACCUM;
            busy_r     <= 1'b1;
            sample_cnt <= '0;
            for (int i = 0; i < NL; i++) acc[i] <= '0;
          end
        end
        ACCUM: begin
          if (bus.abort) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end else if (bus.delta_valid) begin
            for (int i = 0; i < NL; i++) acc[i] <= acc_nxt[i];
            sample_cnt <= sample_cnt + BATCH_LOG2'(1);
            if (sample_cnt == '1) begin
              state  <= APPLY;
              ctrl_r <= 4'b0001;
              step_r <= step_cnt;
              for (int i = 0; i < NL; i++) dlt[i] <= dlt_nxt[i];
            end
          end
        end
        APPLY: begin
          state    <= DONE;
          ctrl_r   <= 4'd0;
          step_r   <= 4'd0;
          done_r   <= 1'b1;
          upd_cnt  <= upd_cnt + 16'd1;
          // Step 0 would make the bias bank ignore an intended update, so skip it on wrap.
          step_cnt <= (step_cnt == 4'd15) ? 4'd1 : step_cnt + 4'd1;
          for (int i = 0; i < NL; i++) dlt[i] <= '0;
        end
        DONE: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ctrl         = ctrl_r;
  assign bus.step         = step_r;
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.update_count = upd_cnt;
  assign bus.deltab2_1    = dlt[0];
  assign bus.deltab2_2    = dlt[1];
  assign bus.deltab2_3    = dlt[2];
  assign bus.deltab2_4    = dlt[3];
  assign bus.deltab2_5    = dlt[4];

endmodule

// File: tb/tb_bias2_update_sched.sv
// Drives two scheduler instances (LR_SHIFT 0 and 1) with identical stimulus and checks
// their bias-bank activity against floor-average arithmetic on the stored batch samples.
module tb_bias2_update_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               start_i, abort_i, dv_i;
  logic signed [15:0] gi [5];

  bias2_update_sched_if bus0();
  bias2_update_sched_if bus1();

  assign bus0.start = start_i;  assign bus1.start = start_i;
  assign bus0.abort = abort_i;  assign bus1.abort = abort_i;
  assign bus0.delta_valid = dv_i; assign bus1.delta_valid = dv_i;
  assign bus0.g1 = gi[0]; assign bus1.g1 = gi[0];
  assign bus0.g2 = gi[1]; assign bus1.g2 = gi[1];
  assign bus0.g3 = gi[2]; assign bus1.g3 = gi[2];
  assign bus0.g4 = gi[3]; assign bus1.g4 = gi[3];
  assign bus0.g5 = gi[4]; assign bus1.g5 = gi[4];

  bias2_update_sched #(.BATCH_LOG2(2), .LR_SHIFT(0), .ACC_W(24)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  bias2_update_sched #(.BATCH_LOG2(2), .LR_SHIFT(1), .ACC_W(24)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic [3:0]       o_ctrl [2];
  logic [3:0]       o_step [2];
  logic [4:0][15:0] o_d    [2];
  logic             o_busy [2];
  logic             o_done [2];
  logic [15:0]      o_uc   [2];

  assign o_ctrl[0] = bus0.ctrl;  assign o_ctrl[1] = bus1.ctrl;
  assign o_step[0] = bus0.step;  assign o_step[1] = bus1.step;
  assign o_busy[0] = bus0.busy;  assign o_busy[1] = bus1.busy;
  assign o_done[0] = bus0.done;  assign o_done[1] = bus1.done;
  assign o_uc[0]   = bus0.update_count; assign o_uc[1] = bus1.update_count;
  assign o_d[0] = {bus0.deltab2_5, bus0.deltab2_4, bus0.deltab2_3, bus0.deltab2_2, bus0.deltab2_1};
  assign o_d[1] = {bus1.deltab2_5, bus1.deltab2_4, bus1.deltab2_3, bus1.deltab2_2, bus1.deltab2_1};

  typedef struct packed {
    logic [3:0]       step;
    logic [4:0][15:0] d;
    logic [31:0]      cyc;
  } ap_t;

  int  cyc = 0;
  ap_t apq0[$], apq1[$];
  int  dq0[$], dq1[$];
  int  viol [2] = '{0, 0};
  int  n_cmp = 0, n_fail = 0;
  int  n_upd = 0;
  logic signed [15:0] smp [4][5];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every apply and done cycle; count any cycle where the bank drive is inconsistent.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      ap_t r;
      if (o_ctrl[k] !== 4'd0) begin
        r.step = o_step[k];
        r.d    = o_d[k];
        r.cyc  = 32'(cyc);
        if (k == 0) apq0.push_back(r); else apq1.push_back(r);
      end
      if (o_done[k] === 1'b1) begin
        if (k == 0) dq0.push_back(cyc); else dq1.push_back(cyc);
      end
      if ((o_ctrl[k] === 4'd1 && o_step[k] === 4'd0) ||
          (o_ctrl[k] !== 4'd1 && (o_ctrl[k] !== 4'd0 || o_step[k] !== 4'd0 || o_d[k] !== '0)))
        viol[k] = viol[k] + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] exp_lane(int lane, int sh);
    longint sum, d, q;
    sum = 0;
    for (int s = 0; s < 4; s++) sum += longint'(smp[s][lane]);
    d = longint'(1) << sh;
    q = sum / d;
    if ((sum % d) != 0 && sum < 0) q = q - 1;
    return q[15:0];
  endfunction

  task automatic rand_g();
    for (int l = 0; l < 5; l++) gi[l] = 16'($urandom);
  endtask

  task automatic clear_smp();
    for (int s = 0; s < 4; s++)
      for (int l = 0; l < 5; l++) smp[s][l] = 16'sd0;
  endtask

  task automatic rand_smp();
    for (int s = 0; s < 4; s++)
      for (int l = 0; l < 5; l++) smp[s][l] = 16'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_upd = 0;
    tick();
  endtask

  // One full batch from smp[][], then checks the single apply, done, counters and busy.
  task automatic run_batch(input string nm, input int max_gap, input bit poke);
    int b_ap[2], b_dq[2], b_v[2];
    int last_edge, na, nd, dc;
    ap_t r;
    logic [4:0][15:0] ed;
    logic [3:0] es;
    logic [15:0] eu;
    b_ap[0] = apq0.size(); b_ap[1] = apq1.size();
    b_dq[0] = dq0.size();  b_dq[1] = dq1.size();
    b_v[0]  = viol[0];     b_v[1]  = viol[1];
    last_edge = 0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (o_busy[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL %s dut%0d busy_after_start: got %b want 1", nm, k, o_busy[k]);
      end
    end
    for (int s = 0; s < 4; s++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gap) begin
        dv_i = 1'b0;
        rand_g();
        start_i = poke ? 1'($urandom_range(1, 0)) : 1'b0;
        tick();
      end
      start_i = poke;
      dv_i = 1'b1;
      for (int l = 0; l < 5; l++) gi[l] = smp[s][l];
      last_edge = cyc + 1;
      tick();
    end
    dv_i = 1'b0;
    start_i = 1'b0;
    rand_g();
    repeat (3) tick();
    @(negedge clk);
    es = 4'((n_upd % 15) + 1);
    eu = 16'(n_upd + 1);
    for (int k = 0; k < 2; k++) begin
      for (int l = 0; l < 5; l++) ed[l] = exp_lane(l, 2 + k);
      na = ((k == 0) ? apq0.size() : apq1.size()) - b_ap[k];
      nd = ((k == 0) ? dq0.size() : dq1.size()) - b_dq[k];
      r  = '0;
      dc = -1;
      if (na >= 1) r = (k == 0) ? apq0[b_ap[k]] : apq1[b_ap[k]];
      if (nd >= 1) dc = (k == 0) ? dq0[b_dq[k]] : dq1[b_dq[k]];
      n_cmp++;
      if (na !== 1) begin n_fail++; $display("FAIL %s dut%0d apply_count: got %0d want 1", nm, k, na); end
      n_cmp++;
      if (r.step !== es) begin n_fail++; $display("FAIL %s dut%0d step: got %0d want %0d", nm, k, r.step, es); end
      n_cmp++;
      if (r.d !== ed) begin n_fail++; $display("FAIL %s dut%0d deltas: got %h want %h", nm, k, r.d, ed); end
      n_cmp++;
      if (r.cyc !== 32'(last_edge)) begin n_fail++; $display("FAIL %s dut%0d apply_cycle: got %0d want %0d", nm, k, r.cyc, last_edge); end
      n_cmp++;
      if (nd !== 1) begin n_fail++; $display("FAIL %s dut%0d done_count: got %0d want 1", nm, k, nd); end
      n_cmp++;
      if (dc !== last_edge + 1) begin n_fail++; $display("FAIL %s dut%0d done_cycle: got %0d want %0d", nm, k, dc, last_edge + 1); end
      n_cmp++;
      if (o_uc[k] !== eu) begin n_fail++; $display("FAIL %s dut%0d update_count: got %0d want %0d", nm, k, o_uc[k], eu); end
      n_cmp++;
      if (o_busy[k] !== 1'b0) begin n_fail++; $display("FAIL %s dut%0d busy_end: got %b want 0", nm, k, o_busy[k]); end
      n_cmp++;
      if (viol[k] !== b_v[k]) begin n_fail++; $display("FAIL %s dut%0d bank_drive: got %0d bad cycles want 0", nm, k, viol[k] - b_v[k]); end
    end
    n_upd++;
  endtask

  task automatic check_idle_zero(input string nm);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({o_ctrl[k], o_step[k], o_d[k], o_busy[k], o_done[k], o_uc[k]} !== '0) begin
        n_fail++;
        $display("FAIL %s dut%0d outputs: got ctrl=%0d step=%0d d=%h busy=%b done=%b uc=%0d want all 0",
                 nm, k, o_ctrl[k], o_step[k], o_d[k], o_busy[k], o_done[k], o_uc[k]);
      end
    end
  endtask

  // Aborted batch: nothing applied, busy low, counters unchanged.
  task automatic check_no_update(input string nm, input int b0, input int b1);
    for (int k = 0; k < 2; k++) begin
      int na;
      na = ((k == 0) ? apq0.size() : apq1.size()) - ((k == 0) ? b0 : b1);
      n_cmp++;
      if (na !== 0) begin n_fail++; $display("FAIL %s dut%0d apply_count: got %0d want 0", nm, k, na); end
      n_cmp++;
      if (o_busy[k] !== 1'b0 || o_uc[k] !== 16'(n_upd)) begin
        n_fail++;
        $display("FAIL %s dut%0d busy/uc: got %b/%0d want 0/%0d", nm, k, o_busy[k], o_uc[k], n_upd);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b0;
    n_upd = 0;
    tick();
  endtask

  task automatic test_basic_average();
    clear_smp();
    smp[0][0] = 16'sd4; smp[1][0] = 16'sd8; smp[2][0] = 16'sd12; smp[3][0] = 16'sd16;
    run_batch("basic", 0, 1'b0);
  endtask

  task automatic test_negative_rounding();
    clear_smp();
    smp[0][1] = -16'sd1; smp[1][1] = -16'sd1; smp[2][1] = -16'sd1; smp[3][1] = -16'sd2;
    run_batch("neg_floor", 0, 1'b0);
    clear_smp();
    for (int s = 0; s < 4; s++) smp[s][1] = -16'sd32768;
    run_batch("neg_extreme", 0, 1'b0);
  endtask

  task automatic test_gapped();
    clear_smp();
    for (int s = 0; s < 4; s++) smp[s][2] = 16'sd100;
    run_batch("gapped", 3, 1'b0);
  endtask

  task automatic test_ignored_start();
    rand_smp();
    run_batch("start_poke", 2, 1'b1);
  endtask

  task automatic test_abort();
    int b0, b1;
    b0 = apq0.size(); b1 = apq1.size();
    start_i = 1'b1; tick(); start_i = 1'b0;
    repeat (2) begin dv_i = 1'b1; rand_g(); tick(); end
    dv_i = 1'b0; abort_i = 1'b1; tick(); abort_i = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    check_no_update("abort", b0, b1);
    clear_smp();
    for (int s = 0; s < 4; s++) smp[s][3] = 16'sd7;
    run_batch("abort_clean", 0, 1'b0);
  endtask

  task automatic test_abort_vs_valid();
    int b0, b1;
    b0 = apq0.size(); b1 = apq1.size();
    start_i = 1'b1; tick(); start_i = 1'b0;
    dv_i = 1'b1; rand_g(); tick();
    abort_i = 1'b1; rand_g(); tick();
    abort_i = 1'b0;
    repeat (4) begin rand_g(); tick(); end  // valid while idle must be ignored
    dv_i = 1'b0;
    @(negedge clk);
    check_no_update("abort_valid", b0, b1);
    rand_smp();
    run_batch("after_abort", 1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 5; i++) begin
      rand_smp();
      run_batch("random", 3, 1'(i % 2));
    end
  endtask

  task automatic test_reset_mid();
    start_i = 1'b1; tick(); start_i = 1'b0;
    repeat (2) begin dv_i = 1'b1; rand_g(); tick(); end
    rst = 1'b1; tick();
    @(negedge clk);
    check_idle_zero("reset_mid");
    rst = 1'b0; dv_i = 1'b0; n_upd = 0;
    tick();
    rand_smp();
    run_batch("post_reset", 0, 1'b0);
  endtask

  task automatic test_step_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      rand_smp();
      run_batch("step_wrap", 0, 1'b0);
    end
  endtask

  task automatic test_reset_in_apply();
    start_i = 1'b1; tick(); start_i = 1'b0;
    repeat (4) begin dv_i = 1'b1; rand_g(); tick(); end
    dv_i = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (o_ctrl[k] !== 4'd1) begin n_fail++; $display("FAIL apply_before_rst dut%0d ctrl: got %0d want 1", k, o_ctrl[k]); end
    end
    rst = 1'b1; tick();
    @(negedge clk);
    check_idle_zero("reset_in_apply");
    rst = 1'b0; n_upd = 0;
    tick();
    rand_smp();
    run_batch("post_apply_reset", 0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; dv_i = 1'b0;
    for (int l = 0; l < 5; l++) gi[l] = 16'sd0;
    test_reset();
    test_basic_average();
    test_negative_rounding();
    test_gapped();
    test_ignored_start();
    test_abort();
    test_abort_vs_valid();
    test_random();
    test_reset_mid();
    test_step_wrap();
    test_reset_in_apply();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bias2_update_sched.md
Name: bias2_update_sched

Overview:
- Sequencer for the output-layer bias update in the DQN training path.
- Collects a mini-batch of per-sample bias gradients (five lanes, one per output neuron) from backprop and averages/scales them.
- Drives the bias2 register bank's ctrl, step and deltab2_1..5 inputs for exactly one update cycle per batch.
- Owns the step counter, so the bias bank never sees step=0 while an update is intended.

Parameters:
- BATCH_LOG2, 2: log2 of samples per mini-batch (batch = 4).
- LR_SHIFT, 0: extra arithmetic right shift applied as learning-rate scaling.
- ACC_W, 24: accumulator width per lane; must be ≥ 16+BATCH_LOG2.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begins a new batch when idle
- abort  in  1  discard the current batch and return to idle
- delta_valid  in  1  one sample's five gradients present this cycle
- g1, g2, g3, g4, g5  in  16 each (signed)  per-sample bias gradients
- ctrl  out  4  bias bank control; 4'b0001 = apply, else 4'b0000
- step  out  4  bias bank step; nonzero only in the apply cycle
- deltab2_1..deltab2_5  out  16 each (signed)  scaled averaged deltas
- busy  out  1  high from accepted start until done
- done  out  1  single-cycle pulse after an update is applied
- update_count  out  16  number of completed updates, wraps at 2^16

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high.
- All outputs are registered.
- Reset values:
  - state IDLE; ctrl=0, step=0, deltab2_*=0, busy=0, done=0, update_count=0.
  - Internal step_cnt=1; accumulators=0; sample_cnt=0.
  - Reset wins over every other input, including mid-batch; no update is issued.
- FSM states: IDLE, ACCUM, APPLY, DONE.
- IDLE:
  - start=1 → ACCUM next cycle, busy=1, accumulators and sample_cnt cleared.
  - delta_valid is ignored.
- ACCUM:
  - Each cycle with delta_valid=1: acc_i += sign-extended g_i, and sample_cnt++.
  - When the sample with sample_cnt = 2^BATCH_LOG2−1 is accepted → APPLY.
  - delta_valid=0 holds all state, with no timeout.
  - abort=1 → IDLE, busy=0, no bias write. Abort takes priority over delta_valid in the same cycle.
  - start while busy is ignored in every non-IDLE state.
- APPLY (exactly one cycle):
  - ctrl=4'b0001, step=step_cnt.
  - deltab2_i = low 16 bits of (acc_i >>> (BATCH_LOG2+LR_SHIFT)). The shift is arithmetic, floor toward −inf.
  - The result always fits in 16 signed bits, so no saturation is needed.
  - The bias bank commits on the edge ending this cycle.
  - abort is ignored in APPLY and DONE.
- DONE (one cycle):
  - done=1, ctrl=0, step=0, deltab2_* driven to 0.
  - update_count++.
  - step_cnt++, wrapping 15→1 (never 0).
  - Next state IDLE; busy drops in the cycle after done.
- Outside APPLY, ctrl=0 and step=0, so the bias bank holds.
- Latency: last sample accepted at edge N → APPLY visible after N (cycle N+1) → done visible after edge N+1 → busy=0 after edge N+2.
- Minimum batch duration is 2^BATCH_LOG2 + 3 cycles from start.

Test Plan:
- Basic average (BATCH_LOG2=2, LR_SHIFT=0):
  - Stimulus: start; lane1 g1 = 4, 8, 12, 16 on consecutive valid cycles; all other lanes 0.
  - Required: exactly one cycle with ctrl=0001, step=1, deltab2_1=10, other lanes 0; done one cycle later; update_count=1.
- Negative rounding:
  - Stimulus: g2 = −1, −1, −1, −2.
  - Required: deltab2_2 = −2 (floor of −5/4); g2 = −32768 ×4 gives −32768 with no overflow.
- Gapped valid and LR_SHIFT=1:
  - Stimulus: samples separated by 0–3 idle cycles; g3 = 100 ×4.
  - Required: APPLY occurs only after the 4th valid; deltab2_3=50.
- Step wrap:
  - Stimulus: 16 back-to-back batches.
  - Required: APPLY step values 1..15 then 1; step is never 0 while ctrl=0001; update_count=16.
- Abort and ignored start:
  - Stimulus: abort after 2 samples → no ctrl=0001, busy=0, next batch starts from clean accumulators.
  - Stimulus: start pulses during ACCUM → no effect.
  - Stimulus: abort and delta_valid together → abort wins.
- Reset mid-operation:
  - Stimulus: rst during ACCUM.
  - Required: all outputs reset values, step_cnt=1; rst asserted in APPLY cycle's next edge forces ctrl=0 from the following cycle.
